sejf_lock_ctrl: RTL and testbench

Sequencing controller for the safe's code-digit comparator. It steps the comparator's `sel` through code stages 0, 1 and 2 as the user confirms each two-digit BCD entry, and samples the comparator's `eq` result. It then drives the lock, the failed-attempt count and the alarm lockout. It sits between the keypad/debounce front end (source of the `enter`/`close` pulses) and the lock actuator and display logic.

---
 rtl/sejf_pkg.sv | 48 ++++
 rtl/sejf_timer.sv | 27 ++
 rtl/sejf_lock_ctrl.sv | 122 ++++++++++++
 tb/tb_sejf_lock_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/sejf_pkg.sv
// Shared types and constants for the safe lock controller: state encoding,
// the comparator's "no stage" select value and the default interval lengths.
package sejf_pkg;

    typedef enum logic [2:0] {
        S0   = 3'd0,
        S1   = 3'd1,
        S2   = 3'd2,
        OPEN = 3'd3,
        LOCK = 3'd4
    } state_t;

    localparam logic [1:0] SEL_NONE = 2'd3;

    localparam int DEF_MAX_FAIL       = 3;
    localparam int DEF_LOCK_CYCLES    = 50000000;
    localparam int DEF_OPEN_CYCLES    = 250000000;
    localparam int DEF_TIMEOUT_CYCLES = 500000000;

    function automatic logic [1:0] sel_of(input state_t s);
        logic [1:0] r;
        case (s)
            S0:      r = 2'd0;
            S1:      r = 2'd1;
            S2:      r = 2'd2;
            default: r = SEL_NONE;
        endcase
        return r;
    endfunction

    // Display stage: OPEN and LOCK read as stage 0.
    function automatic logic [1:0] stage_of(input state_t s);
        logic [1:0] r;
        case (s)
            S1:      r = 2'd1;
            S2:      r = 2'd2;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sejf_timer.sv
// Loadable down-counter shared by the idle, open and lock intervals.
// Holds at zero once reached; tc flags the terminal count.
module sejf_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign tc = (count_reg == '0);

endmodule

// File: rtl/sejf_lock_ctrl.sv
// Safe lock sequencer: walks the code comparator through three stages,
// then opens the lock or counts the failure and enters alarm lockout.
module sejf_lock_ctrl
    import sejf_pkg::*;
#(
    parameter int MAX_FAIL       = DEF_MAX_FAIL,
    parameter int LOCK_CYCLES    = DEF_LOCK_CYCLES,
    parameter int OPEN_CYCLES    = DEF_OPEN_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enter,
    input  logic       close,
    input  logic       eq,
    output logic [1:0] sel,
    output logic [1:0] stage,
    output logic       unlocked,
    output logic       alarm,
    output logic [3:0] fail_cnt
);

    localparam int MAX_CYC = max3(LOCK_CYCLES, OPEN_CYCLES, TIMEOUT_CYCLES);
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [3:0]    MAX_FAIL_L = 4'(MAX_FAIL);
    localparam logic [TW-1:0] IDLE_LOAD  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] OPEN_LOAD  = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_LOAD  = TW'(LOCK_CYCLES - 1);

    state_t        state_reg, state_next;
    logic [3:0]    fail_reg, fail_next, fail_inc;
    logic [1:0]    stage_reg;
    logic          unlocked_reg, alarm_reg;
    logic          tmr_load, tmr_tc;
    logic [TW-1:0] tmr_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S0;
            fail_reg     <= 4'd0;
            stage_reg    <= 2'd0;
            unlocked_reg <= 1'b0;
            alarm_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fail_reg     <= fail_next;
            stage_reg    <= stage_of(state_next);
            unlocked_reg <= (state_next == OPEN);
            alarm_reg    <= (state_next == LOCK);
        end
    end

    always_comb begin
        state_next = state_reg;
        fail_next  = fail_reg;
        fail_inc   = fail_reg + 4'd1;
        case (state_reg)
            S0, S1, S2: begin
                // An enter in the timeout cycle takes priority over the abort.
                if (enter) begin
                    if (eq) begin
                        if (state_reg == S2) begin
                            state_next = OPEN;
                            fail_next  = 4'd0;
                        end else begin
                            state_next = (state_reg == S0) ? S1 : S2;
                        end
                    end else if (fail_inc == MAX_FAIL_L) begin
                        state_next = LOCK;
                        fail_next  = 4'd0;
                    end else begin
                        state_next = S0;
                        fail_next  = fail_inc;
                    end
                end else if (state_reg != S0 && tmr_tc) begin
                    state_next = S0;
                end
            end
            OPEN: begin
                if (close || tmr_tc) begin
                    state_next = S0;
                end
            end
            LOCK: begin
                if (tmr_tc) begin
                    state_next = S0;
                end
            end
            default: state_next = S0;
        endcase
    end

    // The interval timer restarts whenever the state changes; the load value
    // is one less than the interval so tc marks the last cycle in the state.
    always_comb begin
        tmr_load = (state_next != state_reg);
        case (state_next)
            S1, S2:  tmr_val = IDLE_LOAD;
            OPEN:    tmr_val = OPEN_LOAD;
            LOCK:    tmr_val = LOCK_LOAD;
            default: tmr_val = '0;
        endcase
    end

    sejf_timer #(
        .W(TW)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .load_val(tmr_val),
        .tc      (tmr_tc)
    );

    assign sel      = sel_of(state_reg);
    assign stage    = stage_reg;
    assign unlocked = unlocked_reg;
    assign alarm    = alarm_reg;
    assign fail_cnt = fail_reg;

endmodule

// File: tb/tb_sejf_lock_ctrl.sv
// Bench for sejf_lock_ctrl with short intervals; eq is modelled as a
// comparator that matches on any real stage when the entered code is good.
module tb_sejf_lock_ctrl;

    typedef struct packed {
        logic [1:0] sel;
        logic [1:0] stage;
        logic       unl;
        logic       alarm;
        logic [3:0] fc;
    } obs_t;

    typedef struct {
        logic  en;
        logic  cl;
        logic  good;
        obs_t  exp;
        string name;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enter, close, eq, good;
    logic [1:0] sel, stage;
    logic       unlocked, alarm;
    logic [3:0] fail_cnt;

    int   errors = 0;
    int   checks = 0;
    obs_t sb[$];
    vec_t tbl[$];

    sejf_lock_ctrl #(
        .MAX_FAIL      (3),
        .LOCK_CYCLES   (10),
        .OPEN_CYCLES   (20),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enter   (enter),
        .close   (close),
        .eq      (eq),
        .sel     (sel),
        .stage   (stage),
        .unlocked(unlocked),
        .alarm   (alarm),
        .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    assign eq = good && (sel != 2'd3);

    function automatic obs_t mk(input int s, input int st, input int u, input int a, input int f);
        obs_t o;
        o.sel   = 2'(s);
        o.stage = 2'(st);
        o.unl   = 1'(u);
        o.alarm = 1'(a);
        o.fc    = 4'(f);
        return o;
    endfunction

    function automatic void add(input logic e, input logic c, input logic g, input obs_t x, input string nm);
        vec_t v;
        v.en = e; v.cl = c; v.good = g; v.exp = x; v.name = nm;
        tbl.push_back(v);
    endfunction

    task automatic check(input string nm);
        obs_t act, x;
        act = {sel, stage, unlocked, alarm, fail_cnt};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got sel=%0d stage=%0d unl=%0d alarm=%0d fail=%0d",
                     nm, act.sel, act.stage, act.unl, act.alarm, act.fc);
        end else begin
            x = sb.pop_front();
            if (act !== x) begin
                errors++;
                $display("FAIL %s: got sel=%0d stage=%0d unl=%0d alarm=%0d fail=%0d, want sel=%0d stage=%0d unl=%0d alarm=%0d fail=%0d",
                         nm, act.sel, act.stage, act.unl, act.alarm, act.fc,
                         x.sel, x.stage, x.unl, x.alarm, x.fc);
            end else begin
                $display("txn %0d %s: sel=%0d stage=%0d unl=%0d alarm=%0d fail=%0d ok",
                         checks, nm, act.sel, act.stage, act.unl, act.alarm, act.fc);
            end
        end
    endtask

    // Drive one cycle of inputs, expect the outputs after the next edge.
    task automatic step(input logic e, input logic c, input logic g, input obs_t x, input string nm);
        enter = e;
        close = c;
        good  = g;
        sb.push_back(x);
        @(posedge clk);
        #1;
        enter = 1'b0;
        close = 1'b0;
        check(nm);
    endtask

    task automatic now_expect(input obs_t x, input string nm);
        sb.push_back(x);
        check(nm);
    endtask

    initial begin
        rst_n = 1'b0;
        enter = 1'b0;
        close = 1'b0;
        good  = 1'b0;

        // Correct sequence, full open interval with an ignored enter.
        add(1, 0, 1, mk(1, 1, 0, 0, 0), "t1_stage1");
        add(1, 0, 1, mk(2, 2, 0, 0, 0), "t1_stage2");
        add(1, 0, 1, mk(3, 0, 1, 0, 0), "t1_open");
        for (int i = 1; i <= 19; i++) add(i == 5, 0, 1, mk(3, 0, 1, 0, 0), "t1_hold");
        add(0, 0, 0, mk(0, 0, 0, 0, 0), "t1_relock");
        // Lockout with enter/close ignored during alarm.
        add(1, 0, 0, mk(0, 0, 0, 0, 1), "t3_bad1");
        add(1, 0, 0, mk(0, 0, 0, 0, 2), "t3_bad2");
        add(1, 0, 0, mk(3, 0, 0, 1, 0), "t3_lock");
        for (int i = 1; i <= 9; i++) add(i == 2, i == 4, 1, mk(3, 0, 0, 1, 0), "t3_alarm");
        add(0, 0, 0, mk(0, 0, 0, 0, 0), "t3_release");
        // Failures then success clears the count.
        add(1, 0, 1, mk(1, 1, 0, 0, 0), "t6_stage1");
        add(1, 0, 0, mk(0, 0, 0, 0, 1), "t6_bad_s1");
        add(1, 0, 0, mk(0, 0, 0, 0, 2), "t6_bad2");
        add(1, 0, 1, mk(1, 1, 0, 0, 2), "t6_stage1b");
        add(1, 0, 1, mk(2, 2, 0, 0, 2), "t6_stage2b");
        add(1, 0, 1, mk(3, 0, 1, 0, 0), "t6_open");
        add(0, 1, 0, mk(0, 0, 0, 0, 0), "t6_close");
        add(0, 1, 0, mk(0, 0, 0, 0, 0), "t6_close_s0");

        repeat (2) @(posedge clk);
        #1;
        now_expect(mk(0, 0, 0, 0, 0), "reset_state");
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].en, tbl[i].cl, tbl[i].good, tbl[i].exp, tbl[i].name);
        end

        // Early close 5 cycles into OPEN.
        step(1, 0, 1, mk(1, 1, 0, 0, 0), "t2_stage1");
        step(1, 0, 1, mk(2, 2, 0, 0, 0), "t2_stage2");
        step(1, 0, 1, mk(3, 0, 1, 0, 0), "t2_open");
        for (int i = 0; i < 4; i++) step(0, 0, 0, mk(3, 0, 1, 0, 0), "t2_hold");
        step(0, 1, 0, mk(0, 0, 0, 0, 0), "t2_close");

        // Idle timeout in S1 keeps fail_cnt; enter on the timeout cycle wins.
        step(1, 0, 0, mk(0, 0, 0, 0, 1), "t4_bad");
        step(1, 0, 1, mk(1, 1, 0, 0, 1), "t4_stage1");
        for (int i = 0; i < 7; i++) step(0, 0, 0, mk(1, 1, 0, 0, 1), "t4_idle");
        step(0, 0, 0, mk(0, 0, 0, 0, 1), "t4_timeout");
        step(1, 0, 1, mk(1, 1, 0, 0, 1), "t4_stage1b");
        for (int i = 0; i < 7; i++) step(0, 0, 0, mk(1, 1, 0, 0, 1), "t4_idleb");
        step(1, 0, 1, mk(2, 2, 0, 0, 1), "t4_enter_wins");
        for (int i = 0; i < 7; i++) step(0, 0, 0, mk(2, 2, 0, 0, 1), "t4_idle_s2");
        step(0, 0, 0, mk(0, 0, 0, 0, 1), "t4_timeout_s2");

        // Asynchronous reset while open.
        step(1, 0, 1, mk(1, 1, 0, 0, 1), "t5_stage1");
        step(1, 0, 1, mk(2, 2, 0, 0, 1), "t5_stage2");
        step(1, 0, 1, mk(3, 0, 1, 0, 0), "t5_open");
        #2;
        rst_n = 1'b0;
        #1;
        now_expect(mk(0, 0, 0, 0, 0), "t5_async_reset");
        @(posedge clk);
        #1;
        now_expect(mk(0, 0, 0, 0, 0), "t5_held_reset");
        rst_n = 1'b1;
        step(1, 0, 1, mk(1, 1, 0, 0, 0), "t5_after_stage1");
        step(1, 0, 1, mk(2, 2, 0, 0, 0), "t5_after_stage2");
        step(1, 0, 1, mk(3, 0, 1, 0, 0), "t5_after_open");

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
